blob_centroid: RTL and testbench

Consumes the dilated luminance stream produced by the dilation stage, on the same camera video clock. Treats pixels at or above ON_THRESH as object pixels and, per field, accumulates pixel count, coordinate sums and bounding box. At end of field it divides the sums by the count to produce the centroid. Results feed the tracking/overlay logic.

---
 rtl/video_pkg.sv | 20 ++
 rtl/seq_divider.sv | 92 +++++++++
 rtl/blob_centroid.sv | 218 +++++++++++++++++++++
 tb/tb_blob_centroid.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video definitions: decoder sync bit positions, coordinate and
// count widths, and the centroid engine state encoding.
package video_pkg;

  localparam int FVH_FIELD = 2;
  localparam int FVH_VSYNC = 1;
  localparam int FVH_HSYNC = 0;

  localparam int COORD_W = 10;
  localparam int CNT_W   = 19;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_DIVIDE = 1'b1
  } blob_state_t;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock. The first bit is
// resolved on the start edge, so done pulses DATA_W-1 cycles after start is
// sampled and the truncated quotient is valid while done is high.
module seq_divider
  import video_pkg::*;
#(
  parameter int DATA_W = 29,
  parameter int DIV_W  = CNT_W,
  parameter int QUO_W  = COORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DIV_W-1:0]  divisor,
  output logic              done,
  output logic [QUO_W-1:0]  quotient
);

  localparam int ITER_W = $clog2(DATA_W + 1);

  typedef struct packed {
    logic [DIV_W-1:0]  rem;
    logic [DATA_W-1:0] quo;
  } step_t;

  logic [DIV_W-1:0]  rem;
  logic [DATA_W-1:0] quo;
  logic [DIV_W-1:0]  dvs;
  logic [ITER_W-1:0] iter;
  logic              running;
  step_t             first_s;
  step_t             next_s;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The true difference is always below the divisor, so the low DIV_W bits
  // of the wrapped subtraction are exact.
  function automatic step_t div_step(input logic [DIV_W-1:0]  r,
                                     input logic [DATA_W-1:0] q,
                                     input logic [DIV_W-1:0]  d);
    step_t          s;
    logic [DIV_W:0] sh;
    logic           ge;
    sh    = {r, q[DATA_W-1]};
    ge    = (sh >= {1'b0, d});
    s.rem = ge ? (sh[DIV_W-1:0] - d) : sh[DIV_W-1:0];
    s.quo = {q[DATA_W-2:0], ge};
    return s;
  endfunction

  // Step for the start edge (fresh operands) and for every later edge.
  always_comb begin
    first_s = div_step('0, dividend, divisor);
    next_s  = div_step(rem, quo, dvs);
  end

  // Iteration counter and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      iter    <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        running <= 1'b1;
        iter    <= ITER_W'(DATA_W - 1);
      end else if (running) begin
        iter <= iter - ITER_W'(1);
        if (iter == ITER_W'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  // Remainder / quotient shift register.
  always_ff @(posedge clk) begin
    if (start) begin
      rem <= first_s.rem;
      quo <= first_s.quo;
      dvs <= divisor;
    end else if (running) begin
      rem <= next_s.rem;
      quo <= next_s.quo;
    end
  end

  assign quotient = quo[QUO_W-1:0];

endmodule

// File: rtl/blob_centroid.sv
// Per-field object statistics on the dilated luminance stream: pixel count,
// coordinate sums and bounding box, then centroid by two parallel dividers
// at the vsync rising edge. Small fields skip the divide.
module blob_centroid
  import video_pkg::*;
#(
  parameter logic [7:0]         ON_THRESH = 8'hFF,
  parameter logic [COORD_W-1:0] ROW_START = 10'd0,
  parameter logic [COORD_W-1:0] ROW_STEP  = 10'd2,
  parameter logic [COORD_W-1:0] COL_MAX   = 10'd720,
  parameter logic [CNT_W-1:0]   MIN_COUNT = 19'd16,
  parameter int                 SUM_W     = 29
) (
  input  logic               vclk,
  input  logic               reset_n,
  input  logic [2:0]         fvh,
  input  logic               dv,
  input  logic [7:0]         pixel,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic [COORD_W-1:0] xmin,
  output logic [COORD_W-1:0] xmax,
  output logic [COORD_W-1:0] ymin,
  output logic [COORD_W-1:0] ymax,
  output logic [CNT_W-1:0]   count,
  output logic               found,
  output logic               result_valid,
  output logic               busy,
  output logic               overrun
);

  blob_state_t        state;
  coord_t             col, row;
  logic               line_seen;
  logic               vs_prev, hs_prev;
  logic               vs_rise, hs_rise;
  logic               vid, active, obj;
  logic               take_field;
  logic [SUM_W-1:0]   col_ext, row_ext;

  cnt_t               acc_count;
  logic [SUM_W-1:0]   sumx, sumy;
  coord_t             bxmin, bxmax, bymin, bymax;

  cnt_t               h_count;
  logic [SUM_W-1:0]   h_sumx, h_sumy;
  coord_t             h_xmin, h_xmax, h_ymin, h_ymax;

  logic               start_div;
  logic               done_x, done_y;
  coord_t             qx, qy;

  assign vid        = dv && (fvh == 3'b000);
  assign active     = vid && (col < COL_MAX);
  assign obj        = active && (pixel >= ON_THRESH);
  assign vs_rise    = fvh[FVH_VSYNC] && !vs_prev;
  assign hs_rise    = fvh[FVH_HSYNC] && !hs_prev;
  assign take_field = (state == ST_ACCUM) && vs_rise && (acc_count >= MIN_COUNT);
  assign col_ext    = {{(SUM_W-COORD_W){1'b0}}, col};
  assign row_ext    = {{(SUM_W-COORD_W){1'b0}}, row};
  assign busy       = (state == ST_DIVIDE);

  // Raster position: column within the line, row within the field.
  always_ff @(posedge vclk or negedge reset_n) begin
    if (!reset_n) begin
      col       <= '0;
      row       <= ROW_START;
      line_seen <= 1'b0;
      vs_prev   <= 1'b0;
      hs_prev   <= 1'b0;
    end else begin
      vs_prev <= fvh[FVH_VSYNC];
      hs_prev <= fvh[FVH_HSYNC];
      if (vs_rise) begin
        col       <= '0;
        row       <= ROW_START;
        line_seen <= 1'b0;
      end else begin
        if (hs_rise)
          col <= '0;
        else if (vid && (col != '1))
          col <= col + COORD_W'(1);
        if (active)
          line_seen <= 1'b1;
        else if (hs_rise && line_seen) begin
          row       <= row + ROW_STEP;
          line_seen <= 1'b0;
        end
      end
    end
  end

  // Field accumulators; a field end restarts them with the current pixel.
  always_ff @(posedge vclk or negedge reset_n) begin
    if (!reset_n) begin
      acc_count <= '0;
      sumx      <= '0;
      sumy      <= '0;
      bxmin     <= '0;
      bxmax     <= '0;
      bymin     <= '0;
      bymax     <= '0;
    end else if (vs_rise) begin
      acc_count <= obj ? CNT_W'(1) : '0;
      sumx      <= obj ? col_ext : '0;
      sumy      <= obj ? row_ext : '0;
      bxmin     <= obj ? col : '0;
      bxmax     <= obj ? col : '0;
      bymin     <= obj ? row : '0;
      bymax     <= obj ? row : '0;
    end else if (obj) begin
      acc_count <= acc_count + CNT_W'(1);
      sumx      <= sumx + col_ext;
      sumy      <= sumy + row_ext;
      if (acc_count == '0) begin
        bxmin <= col;
        bxmax <= col;
        bymin <= row;
        bymax <= row;
      end else begin
        if (col < bxmin) bxmin <= col;
        if (col > bxmax) bxmax <= col;
        if (row < bymin) bymin <= row;
        if (row > bymax) bymax <= row;
      end
    end
  end

  // Holding registers: a completed field's totals, frozen for the divide.
  always_ff @(posedge vclk) begin
    if (take_field) begin
      h_count <= acc_count;
      h_sumx  <= sumx;
      h_sumy  <= sumy;
      h_xmin  <= bxmin;
      h_xmax  <= bxmax;
      h_ymin  <= bymin;
      h_ymax  <= bymax;
    end
  end

  seq_divider #(.DATA_W(SUM_W), .DIV_W(CNT_W), .QUO_W(COORD_W)) u_div_x (
    .clk      (vclk),
    .rst_n    (reset_n),
    .start    (start_div),
    .dividend (h_sumx),
    .divisor  (h_count),
    .done     (done_x),
    .quotient (qx)
  );

  seq_divider #(.DATA_W(SUM_W), .DIV_W(CNT_W), .QUO_W(COORD_W)) u_div_y (
    .clk      (vclk),
    .rst_n    (reset_n),
    .start    (start_div),
    .dividend (h_sumy),
    .divisor  (h_count),
    .done     (done_y),
    .quotient (qy)
  );

  // Field-end sequencing and registered result outputs.
  always_ff @(posedge vclk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_ACCUM;
      start_div    <= 1'b0;
      cx           <= '0;
      cy           <= '0;
      xmin         <= '0;
      xmax         <= '0;
      ymin         <= '0;
      ymax         <= '0;
      count        <= '0;
      found        <= 1'b0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      start_div    <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        ST_ACCUM: begin
          if (take_field) begin
            start_div <= 1'b1;
            state     <= ST_DIVIDE;
          end else if (vs_rise) begin
            cx           <= '0;
            cy           <= '0;
            xmin         <= '0;
            xmax         <= '0;
            ymin         <= '0;
            ymax         <= '0;
            count        <= acc_count;
            found        <= 1'b0;
            result_valid <= 1'b1;
          end
        end
        ST_DIVIDE: begin
          if (vs_rise)
            overrun <= 1'b1;
          if (done_x && done_y) begin
            cx           <= qx;
            cy           <= qy;
            xmin         <= h_xmin;
            xmax         <= h_xmax;
            ymin         <= h_ymin;
            ymax         <= h_ymax;
            count        <= h_count;
            found        <= 1'b1;
            result_valid <= 1'b1;
            state        <= ST_ACCUM;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_blob_centroid.sv
// Bench for blob_centroid: drives raster lines, models per-field statistics
// and queues the expected result for each field end.
module tb_blob_centroid;

  logic        vclk    = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  fvh     = 3'b000;
  logic        dv      = 1'b0;
  logic [7:0]  pixel   = 8'h00;
  logic [9:0]  cx, cy, xmin, xmax, ymin, ymax;
  logic [18:0] count;
  logic        found, result_valid, busy, overrun;

  blob_centroid #(
    .ON_THRESH (8'hFF),
    .ROW_START (10'd0),
    .ROW_STEP  (10'd2),
    .COL_MAX   (10'd720),
    .MIN_COUNT (19'd1),
    .SUM_W     (29)
  ) dut (
    .vclk         (vclk),
    .reset_n      (reset_n),
    .fvh          (fvh),
    .dv           (dv),
    .pixel        (pixel),
    .cx           (cx),
    .cy           (cy),
    .xmin         (xmin),
    .xmax         (xmax),
    .ymin         (ymin),
    .ymax         (ymax),
    .count        (count),
    .found        (found),
    .result_valid (result_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 vclk = ~vclk;

  int cyc = 0;
  always @(posedge vclk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int cx, cy, xmin, xmax, ymin, ymax, cnt, found, at, busy_n;
  } res_t;

  res_t sb[$];
  res_t mon_e;

  int m_cnt = 0, m_sx = 0, m_sy = 0;
  int m_xmin = 0, m_xmax = 0, m_ymin = 0, m_ymax = 0;
  int busy_cnt = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_cnt = 0; m_sx = 0; m_sy = 0;
    m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
  endfunction

  function automatic void add_obj(input int c, input int r);
    if (m_cnt == 0) begin
      m_xmin = c; m_xmax = c; m_ymin = r; m_ymax = r;
    end else begin
      if (c < m_xmin) m_xmin = c;
      if (c > m_xmax) m_xmax = c;
      if (r < m_ymin) m_ymin = r;
      if (r > m_ymax) m_ymax = r;
    end
    m_cnt++;
    m_sx += c;
    m_sy += r;
  endfunction

  task automatic drive(input logic [2:0] f, input logic d, input logic [7:0] p);
    fvh = f; dv = d; pixel = p;
    @(posedge vclk);
    #1;
  endtask

  // Line ln of the field: hsync, then npix valid pixels; cols c0..c1 carry val.
  task automatic line(input int ln, input int npix, input int c0, input int c1,
                      input logic [7:0] val);
    drive(3'b001, 1'b0, 8'h00);
    drive(3'b001, 1'b0, 8'h00);
    for (int c = 0; c < npix; c++) begin
      logic [7:0] p;
      p = (c >= c0 && c <= c1) ? val : 8'h00;
      if (p >= 8'hFF && c < 720) add_obj(c, ln * 2);
      drive(3'b000, 1'b1, p);
    end
    drive(3'b000, 1'b0, 8'h00);
  endtask

  // Field end; the expected result is queued when a result is due.
  task automatic vsync(input bit want);
    res_t e;
    if (want) begin
      if (m_cnt >= 1) begin
        e.cx = m_sx / m_cnt;  e.cy = m_sy / m_cnt;
        e.xmin = m_xmin; e.xmax = m_xmax; e.ymin = m_ymin; e.ymax = m_ymax;
        e.cnt = m_cnt; e.found = 1; e.at = cyc + 31; e.busy_n = 30;
      end else begin
        e.cx = 0; e.cy = 0; e.xmin = 0; e.xmax = 0; e.ymin = 0; e.ymax = 0;
        e.cnt = m_cnt; e.found = 0; e.at = cyc + 1; e.busy_n = 0;
      end
      sb.push_back(e);
    end
    model_clear();
    drive(3'b010, 1'b0, 8'h00);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge vclk);
      #1;
      n++;
    end
    chk("result_timeout", sb.size(), 0);
    if (sb.size() != 0) sb.delete();
    drive(3'b000, 1'b0, 8'h00);
  endtask

  // Scoreboard: compare each result pulse with the oldest queued expectation.
  always @(negedge vclk) begin
    if (!reset_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (result_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("cx", cx, mon_e.cx);
          chk("cy", cy, mon_e.cy);
          chk("xmin", xmin, mon_e.xmin);
          chk("xmax", xmax, mon_e.xmax);
          chk("ymin", ymin, mon_e.ymin);
          chk("ymax", ymax, mon_e.ymax);
          chk("count", count, mon_e.cnt);
          chk("found", found, mon_e.found);
          chk("result_cycle", cyc, mon_e.at);
          chk("busy_cycles", busy_cnt, mon_e.busy_n);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge vclk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_cx", cx, 0);
    chk("rst_ymax", ymax, 0);
    chk("rst_found", found, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    reset_n = 1'b1;
    drive(3'b000, 1'b0, 8'h00);

    // Single object pixel at col 10 on the first active line
    line(0, 16, 10, 10, 8'hFF);
    vsync(1);
    wait_idle();

    // 4x3 block at cols 100-103, lines 10-12
    for (int ln = 0; ln < 13; ln++)
      line(ln, 110, 100, 103, (ln >= 10) ? 8'hFF : 8'h00);
    vsync(1);
    wait_idle();

    // Reset in the middle of active video
    drive(3'b001, 1'b0, 8'h00);
    drive(3'b001, 1'b0, 8'h00);
    repeat (5) drive(3'b000, 1'b1, 8'hFF);
    reset_n = 1'b0;
    #2;
    chk("midrst_count", count, 0);
    chk("midrst_cx", cx, 0);
    chk("midrst_xmax", xmax, 0);
    chk("midrst_found", found, 0);
    chk("midrst_busy", busy, 0);
    drive(3'b000, 1'b1, 8'hFF);
    drive(3'b000, 1'b1, 8'hFF);
    reset_n = 1'b1;
    model_clear();
    line(0, 8, 5, 5, 8'hFF);
    line(1, 8, 7, 7, 8'hFF);
    vsync(1);
    wait_idle();

    // Field of 8'hFE only: nothing counted, no divide
    for (int ln = 0; ln < 3; ln++)
      line(ln, 20, 0, 19, 8'hFE);
    vsync(1);
    wait_idle();

    // Columns >= 720 and pixels outside active video are ignored
    line(0, 725, 719, 724, 8'hFF);
    repeat (3) drive(3'b100, 1'b1, 8'hFF);
    repeat (2) drive(3'b001, 1'b1, 8'hFF);
    repeat (3) drive(3'b000, 1'b0, 8'hFF);
    line(1, 8, 3, 3, 8'hFF);
    vsync(1);
    wait_idle();

    // Field end while dividing: overrun, second field dropped
    chk("overrun_clear", overrun, 0);
    line(0, 10, 2, 5, 8'hFF);
    vsync(1);
    repeat (20) drive(3'b000, 1'b1, 8'hFF);
    vsync(0);
    drive(3'b000, 1'b0, 8'h00);
    chk("overrun_set", overrun, 1);
    wait_idle();
    line(0, 16, 8, 12, 8'hFF);
    vsync(1);
    wait_idle();
    chk("overrun_sticky", overrun, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
